// File: rtl/mv_result_rx.sv
// mv_result_rx: receive side of the mv_mul_4x4_fp32 result stream.
// Captures every (non-stallable) multiplier result into a DEPTH-entry FIFO and
// re-presents it downstream with a valid/ready handshake, while a credit
// counter throttles the upstream vertex feeder so results are never dropped.
//
// Optional feature: define MV_RX_ID_CHECK_EN to enable the vertex ID sequence
// checker driving seq_err. Without it seq_err is tied to 0.
//
// Handshake: a downstream transfer happens on a rising edge where
// out_valid && out_ready are both high. out_valid never depends on out_ready,
// and the head entry stays stable until it is transferred.
module mv_result_rx #(
    parameter int IDW   = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // feeder side
    input  logic                     issue,
    output logic                     can_issue,
    output logic [$clog2(DEPTH):0]   credits,
    // multiplier result stream
    input  logic                     in_valid,
    input  logic [IDW-1:0]           in_vertex_id,
    input  logic [31:0]              ix,
    input  logic [31:0]              iy,
    input  logic [31:0]              iz,
    input  logic [31:0]              iw,
    // downstream
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDW-1:0]           out_vertex_id,
    output logic [31:0]              ox,
    output logic [31:0]              oy,
    output logic [31:0]              oz,
    output logic [31:0]              ow,
    // status
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err,
    output logic                     issue_err,
    output logic                     seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO storage; deliberately not reset.
    logic [IDW-1:0] id_mem [DEPTH];
    logic [31:0]    x_mem  [DEPTH];
    logic [31:0]    y_mem  [DEPTH];
    logic [31:0]    z_mem  [DEPTH];
    logic [31:0]    w_mem  [DEPTH];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           full;
    logic           pop;
    logic           push_ok;
    logic [CW-1:0]  count_nxt;
    logic [CW-1:0]  credits_nxt;
    logic           issue_bad;

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // When full, a push is only taken if the head leaves in the same cycle.
    assign push_ok   = in_valid && (!full || pop);

    // Head outputs read the entry at the read pointer, zeroed when empty.
    assign out_vertex_id = out_valid ? id_mem[rd_ptr] : '0;
    assign ox            = out_valid ? x_mem[rd_ptr]  : '0;
    assign oy            = out_valid ? y_mem[rd_ptr]  : '0;
    assign oz            = out_valid ? z_mem[rd_ptr]  : '0;
    assign ow            = out_valid ? w_mem[rd_ptr]  : '0;

    // Occupancy next-state from accepted push and pop.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Credit next-state: issue takes one, pop returns one; a simultaneous pair
    // cancels, which also covers an issue at zero credits that coincides with
    // a pop (the returning credit is reused in the same cycle).
    always_comb begin
        credits_nxt = credits;
        issue_bad   = 1'b0;
        if (issue && !pop) begin
            if (credits != '0) begin
                credits_nxt = credits - 1'b1;
            end else begin
                issue_bad = 1'b1;
            end
        end else if (pop && !issue) begin
            if (credits != DEPTH_C) begin
                credits_nxt = credits + 1'b1;
            end
        end
    end

    // Storage write on every accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            id_mem[wr_ptr] <= in_vertex_id;
            x_mem[wr_ptr]  <= ix;
            y_mem[wr_ptr]  <= iy;
            z_mem[wr_ptr]  <= iz;
            w_mem[wr_ptr]  <= iw;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Credit counter with registered can_issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits   <= DEPTH_C;
            can_issue <= 1'b1;
        end else begin
            credits   <= credits_nxt;
            can_issue <= (credits_nxt != '0);
        end
    end

    // Sticky error flags for dropped pushes and issues without credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
            issue_err    <= 1'b0;
        end else begin
            if (in_valid && !push_ok) begin
                overflow_err <= 1'b1;
            end
            if (issue_bad) begin
                issue_err <= 1'b1;
            end
        end
    end

`ifdef MV_RX_ID_CHECK_EN
    logic [IDW-1:0] exp_id;

    // ID sequence check: compare each accepted ID with the expected one, then
    // resync to id+1 so a single gap flags exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_id  <= '0;
            seq_err <= 1'b0;
        end else if (push_ok) begin
            if (in_vertex_id != exp_id) begin
                seq_err <= 1'b1;
            end
            exp_id <= in_vertex_id + 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule
